// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider: bus widths, FSM state encodings
// and handshake constants.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Counter value of the iteration that produces the final quotient bit.
  localparam logic [5:0] DivLastIter = 6'd31;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] neg_word(input logic [RegBus-1:0] v);
    return ZeroWord - v;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider, one quotient bit per clock.
// Signed operation is built only when DIV_SIGNED_EN is defined.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [64:0]             work_q, work_d;
  logic [RegBus-1:0]       dvs_q, dvs_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [64:0]       shifted, step;
  logic [32:0]       diff;
  logic [RegBus-1:0] op1_mag, op2_mag, quo_fix, rem_fix;
  logic              unused_top;

  // Partial remainder never reaches the divisor, so the top bit stays zero.
  assign unused_top = work_q[64];
  assign shifted    = {work_q[63:0], 1'b0};
  assign diff       = shifted[64:32] - {1'b0, dvs_q};
  assign step       = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d, negr_q, negr_d;
  logic op1_neg, op2_neg;

  assign op1_neg = signed_div_i & opdata1_i[31];
  assign op2_neg = signed_div_i & opdata2_i[31];
  assign op1_mag = op1_neg ? neg_word(opdata1_i) : opdata1_i;
  assign op2_mag = op2_neg ? neg_word(opdata2_i) : opdata2_i;
  assign quo_fix = negq_q ? neg_word(step[31:0])  : step[31:0];
  assign rem_fix = negr_q ? neg_word(step[63:32]) : step[63:32];

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == DivFree && start_i == DivStart && !annul_i) begin
      negq_d = op1_neg ^ op2_neg;
      negr_d = op1_neg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
  assign op1_mag = opdata1_i;
  assign op2_mag = opdata2_i;
  assign quo_fix = step[31:0];
  assign rem_fix = step[63:32];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = 6'd0;
            work_d  = {33'b0, op1_mag};
            dvs_d   = op2_mag;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else begin
          state_d  = DivEnd;
          result_d = {ZeroWord, ZeroWord};
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == DivLastIter) begin
            state_d  = DivEnd;
            result_d = {rem_fix, quo_fix};
            ready_d  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= 6'd0;
      work_q   <= 65'd0;
      dvs_q    <= ZeroWord;
      result_q <= {ZeroWord, ZeroWord};
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Randomized bench for the divider: an arithmetic reference model plus a
// per-cycle compare of ready_o/result_o, and directed literal cases.
module tb_div;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        start = 1'b0, annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  div dut (
    .clk          (clk),
    .rst          (rst_n),
    .signed_div_i (sgn),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: 64-bit division cannot overflow for 32-bit operands.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic   sg;
    sg = s & SIGNED_EN;
    if (b == 32'd0) return 64'd0;
    sa = (sg && a[31]) ? -longint'({32'd0, -a}) : longint'({32'd0, a});
    sb = (sg && b[31]) ? -longint'({32'd0, -b}) : longint'({32'd0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level timing model: captures the expected answer at acceptance.
  logic [63:0] m_exp = '0, m_res = '0;
  logic        m_rdy = 1'b0, m_busy = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0; m_res <= '0; m_busy <= 1'b0; m_left <= 0; m_exp <= '0;
    end else if (m_rdy) begin
      if (annul || !start) begin m_rdy <= 1'b0; m_res <= '0; end
    end else if (m_busy) begin
      if (annul) m_busy <= 1'b0;
      else if (m_left == 1) begin m_busy <= 1'b0; m_rdy <= 1'b1; m_res <= m_exp; end
      else m_left <= m_left - 1;
    end else if (start && !annul) begin
      m_exp  <= ref_div(op1, op2, sgn);
      m_busy <= 1'b1;
      m_left <= (op2 == 32'd0) ? 1 : 32;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("cyc_ready", {63'd0, ready}, {63'd0, m_rdy});
      check("cyc_result", result, m_res);
    end
  end

  // One request; lat = edges after acceptance until ready_o is seen (-1 if none).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int annul_at, input int hold, input bit scramble,
                        input bit end_annul, output logic [63:0] res, output int lat);
    bit got = 1'b0, annulled = 1'b0;
    res = '0;
    lat = -1;
    @(negedge clk);
    op1 = a; op2 = b; sgn = s; start = 1'b1;
    for (int c = 0; c < 40 && !got && !annulled; c++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1; res = result; lat = c;
      end else if (c == annul_at) begin
        annulled = 1'b1; annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
      end
      if (scramble) begin op1 = $urandom; op2 = $urandom; end
    end
    if (!annulled) check("completed", {63'd0, got}, 64'd1);
    if (got) begin
      repeat (hold) @(negedge clk);
      if (end_annul) begin
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
      end
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [63:0] r;
  int          lat;

  initial begin
    check("pin_u100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    check("pin_ffff_1", ref_div(32'hFFFFFFFF, 32'd1, 1'b0), 64'h00000000_FFFFFFFF);
    check("pin_div0", ref_div(32'd5, 32'd0, 1'b0), 64'd0);
    check("pin_s100_7", ref_div(32'hFFFFFF9C, 32'd7, 1'b1),
          SIGNED_EN ? 64'hFFFFFFFE_FFFFFFF2 : 64'h00000002_24924916);

    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_result", result, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_div(32'd100, 32'd7, 1'b0, -1, 3, 1'b0, 1'b0, r, lat);
    check("u100_7", r, 64'h00000002_0000000E);
    check("u100_7_lat", 64'(lat), 64'd32);

    do_div(32'hFFFFFF9C, 32'd7, 1'b1, -1, 0, 1'b1, 1'b0, r, lat);
    check("s100_7", r, SIGNED_EN ? 64'hFFFFFFFE_FFFFFFF2 : 64'h00000002_24924916);

    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, 1, 1'b0, 1'b0, r, lat);
    check("minint_m1", r, SIGNED_EN ? 64'h00000000_80000000 : 64'h80000000_00000000);

    do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 1, 1'b0, 1'b1, r, lat);
    check("u_minint_m1", r, 64'h80000000_00000000);

    do_div(32'd12345, 32'd0, 1'b0, -1, 2, 1'b0, 1'b0, r, lat);
    check("div0", r, 64'd0);
    check("div0_lat", 64'(lat), 64'd1);

    do_div(32'd100, 32'd7, 1'b0, 10, 0, 1'b0, 1'b0, r, lat);
    check("annul_noready", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
    repeat (40) @(negedge clk);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, -1, 0, 1'b0, 1'b0, r, lat);
    check("ffff_1", r, 64'h00000000_FFFFFFFF);
    check("ffff_1_lat", 64'(lat), 64'd32);

    // Annul held with start in the idle state must not launch a division.
    @(negedge clk);
    op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst_n = 1'b0; start = 1'b0;
    #1;
    check("arst_ready", {63'd0, ready}, 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_div(32'd100, 32'd7, 1'b0, -1, 0, 1'b0, 1'b0, r, lat);
    check("post_rst", r, 64'h00000002_0000000E);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      int          sel, an;
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      an = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 33) : -1;
      do_div(a, b, 1'($urandom_range(0, 1)), an, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, lat);
      if (lat >= 0) check("rand", r, ref_div(a, b, sgn));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider in the EX stage: the responder for divide requests issued by the decode/execute pipeline. The EX stage raises `start_i` with operands from the ID/EX register. The divider computes quotient and remainder with a one-bit-per-cycle restoring algorithm and answers with `ready_o`. The pipeline controller stalls the front end while a division is in flight.

## Interface
- No parameters; widths come from the shared defines (`RegBus` = 32 bits, `DoubleRegBus` = 64 bits).
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `signed_div_i` input 1: 1 = signed divide, 0 = unsigned.
- `opdata1_i` input 32: dividend.
- `opdata2_i` input 32: divisor.
- `start_i` input 1: request; held high by the requester until it has consumed the result.
- `annul_i` input 1: cancel any in-flight or pending division.
- `result_o` output 64: `{remainder[63:32], quotient[31:0]}`; valid only while `ready_o` = 1.
- `ready_o` output 1: result valid.

## Operation
- States: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- `DivFree`:
  - If `start_i` = 1 and `annul_i` = 0 and the divisor is 0, go to `DivByZero`.
  - If `start_i` = 1 and `annul_i` = 0 and the divisor is nonzero, go to `DivOn`: latch operand magnitudes and sign flags, clear the 6-bit iteration counter.
  - Otherwise stay.
- Operand capture:
  - Signed mode: each negative operand is replaced by its two's-complement magnitude.
  - Operand changes after the capture edge are ignored.
- `DivByZero`: next edge goes to `DivEnd`, with `result_o` = 0 and `ready_o` = 1.
- `DivOn`, one iteration per edge:
  - Trial-subtract the divisor from the upper 33 bits of the 65-bit working register.
  - If non-negative, shift in 1 with the difference; else shift in 0.
  - Increment the counter.
  - The 32nd iteration edge performs the final step and goes to `DivEnd`, with `ready_o` = 1 and `result_o` set to the corrected result.
- Sign correction (signed mode):
  - Quotient is negated if sign(op1) XOR sign(op2).
  - Remainder is negated if op1 is negative.
  - 0x80000000 / -1 wraps: quotient = 0x80000000, remainder = 0.
- `DivEnd`:
  - Hold `ready_o` and `result_o` while `start_i` = 1.
  - When `start_i` = 0, go to `DivFree` with `ready_o` = 0 and `result_o` = 0.
- `annul_i` = 1 in `DivOn` or `DivByZero`: next edge goes to `DivFree` with `ready_o` = 0, and no result is produced.
- `annul_i` = 1 in `DivEnd`: go to `DivFree`.
- `annul_i` overrides `start_i` in every state.

## Timing
- Reset (async, `rst` = 0): state `DivFree`, `ready_o` = 0, `result_o` = 0, counter 0, working register 0. A reset asserted mid-division aborts it immediately.
- Latency, counting edge E0 as the edge that samples `start_i` in `DivFree`:
  - Nonzero divisor: `ready_o` rises after E32.
  - Zero divisor: `ready_o` rises after E1.
- Back-to-back divisions: after `DivEnd` → `DivFree` (at least one cycle with `start_i` = 0), a new start is accepted on the following edge.
- `ready_o` and `result_o` are registered; no combinational path from any input to any output.

## Configuration
- `DIV_SIGNED_EN` defined: `signed_div_i` is honoured as described above.
- `DIV_SIGNED_EN` undefined:
  - `signed_div_i` is ignored and every division is unsigned.
  - The sign-flag and negation logic is not built.

## Structure
- Shared defines header holds:
  - State encodings: `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits).
  - Handshake constants: `DivStart`, `DivStop`, `DivResultReady`, `DivResultNotReady`.
  - Width and constant macros: `DoubleRegBus`, `ZeroWord`.
- Single module, no sub-module; the 33-bit trial subtractor stays inline.

## Test plan
- Unsigned 100 / 7, `start_i` held → `ready_o` rises after E32; `result_o` = 0x00000002_0000000E; stays until `start_i` drops, then `ready_o` = 0 and `result_o` = 0 on the next edge.
- Signed -100 (0xFFFFFF9C) / 7 → `result_o` = 0xFFFFFFFE_FFFFFFF2.
- Signed 0x80000000 / 0xFFFFFFFF → `result_o` = 0x00000000_80000000.
- Same operands with `DIV_SIGNED_EN` undefined → unsigned result 0x80000000 / 0xFFFFFFFF, giving `result_o` = 0x80000000_00000000.
- Divisor 0 → `ready_o` after E1 with `result_o` = 0.
- `annul_i` pulsed at iteration 10 → `ready_o` never rises. A subsequent 0xFFFFFFFF / 1 unsigned request → `result_o` = 0x00000000_FFFFFFFF after 32 cycles.
- `rst` asserted low at iteration 20 → outputs 0 and state `DivFree` immediately, without waiting for a clock edge. After release, a new 100 / 7 request completes correctly.
